// File: rtl/gradient_window_ctrl.sv
// Position sequencer for the 5x5 Gx/Gy gradient stage: counts pixels, qualifies complete
// kernel windows and delays valid/SOF/EOF to line up with the datapath output.
module gradient_window_ctrl #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int KERNEL_SIZE  = 5,
    parameter int PIPE_LATENCY = 2
) (
    input  logic                          i_clk,
    input  logic                          i_aresetn,
    input  logic                          i_data_valid,
    input  logic                          i_start_of_frame,
    output logic                          o_kernel_valid,
    output logic                          o_kernel_sof,
    output logic                          o_data_valid,
    output logic                          o_start_of_frame,
    output logic                          o_end_of_frame,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
    output logic                          o_busy,
    output logic                          o_sof_err
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    // Index 0 is the registered kernel-side flag, index PIPE_LATENCY the datapath-aligned one.
    logic [PIPE_LATENCY:0] vld_pipe_q, vld_pipe_d;
    logic [PIPE_LATENCY:0] sof_pipe_q, sof_pipe_d;
    logic [PIPE_LATENCY:0] eof_pipe_q, eof_pipe_d;
    logic                  sof_err_q, sof_err_d;

    logic                  restart, accept, pix_first_win, pix_last, pix_in_win;
    logic [RW-1:0]         pix_row;
    logic [CW-1:0]         pix_col;

    // Indices of the pixel presented this cycle, derived from the last accepted one.
    always_comb begin
        restart = i_data_valid & i_start_of_frame;
        accept  = restart | (i_data_valid & (state_q != IDLE));
        pix_row = row_q;
        pix_col = col_q;
        if (restart) begin
            pix_row = '0;
            pix_col = '0;
        end else if (col_q == COL_LAST) begin
            pix_row = row_q + 1'b1;
            pix_col = '0;
        end else begin
            pix_col = col_q + 1'b1;
        end
        pix_in_win    = (pix_row >= ROW_WIN) && (pix_col >= COL_WIN);
        pix_first_win = (pix_row == ROW_WIN) && (pix_col == COL_WIN);
        pix_last      = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (pix_last)           state_d = IDLE;
            else if (pix_first_win) state_d = RUN;
            else if (restart)       state_d = FILL;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            row_d = pix_row;
            col_d = pix_col;
        end
        // The delay line free-runs so input gaps reach the output unchanged.
        vld_pipe_d = {vld_pipe_q[PIPE_LATENCY-1:0], accept & pix_in_win};
        sof_pipe_d = {sof_pipe_q[PIPE_LATENCY-1:0], accept & pix_first_win};
        eof_pipe_d = {eof_pipe_q[PIPE_LATENCY-1:0], accept & pix_last};
        sof_err_d  = restart & (state_q != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            row_q      <= '0;
            col_q      <= '0;
            vld_pipe_q <= '0;
            sof_pipe_q <= '0;
            eof_pipe_q <= '0;
            sof_err_q  <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            vld_pipe_q <= vld_pipe_d;
            sof_pipe_q <= sof_pipe_d;
            eof_pipe_q <= eof_pipe_d;
            sof_err_q  <= sof_err_d;
        end
    end

    always_comb begin
        o_busy           = (state_q != IDLE);
        o_kernel_valid   = vld_pipe_q[0];
        o_kernel_sof     = sof_pipe_q[0];
        o_data_valid     = vld_pipe_q[PIPE_LATENCY];
        o_start_of_frame = sof_pipe_q[PIPE_LATENCY];
        o_end_of_frame   = eof_pipe_q[PIPE_LATENCY];
        o_row            = row_q;
        o_col            = col_q;
        o_sof_err        = sof_err_q;
    end

endmodule
